ldpc_ber_sweep_ctrl: RTL and testbench
======================================

Name: ldpc_ber_sweep_ctrl

Overview:
Data-clock-domain sequencer that drives the LDPC BER tester datapath through an automatic SNR sweep. For each sweep point it applies the AWGN factor/offset, pulses the datapath soft reset, and enables dataflow. It stops the point on a block or error target, lets the counters settle, then emits one result record. Sits between the regmap's data-side outputs and the AWGN/decoder/counter datapath, so software only programs sweep limits and collects results.

Parameters:
RESET_CYCLES, 4, cycles data_sw_resetn is held low at the start of each point (>=1)
DRAIN_CYCLES, 64, cycles waited after data_en deasserts before sampling counters (>=1)
POINT_WIDTH, 8, width of point count/index

Ports:
data_clk  in  1  clock
data_resetn  in  1  synchronous active-low reset
cfg_start  in  1  single-cycle start pulse; ignored unless IDLE or DONE
cfg_abort  in  1  single-cycle abort pulse
cfg_factor_init  in  16  factor for point 0
cfg_factor_step  in  16  added to factor per point
cfg_offset  in  8  AWGN offset, constant over sweep
cfg_num_points  in  POINT_WIDTH  points to run; 0 = complete immediately
cfg_max_blocks  in  64  block target per point (0 treated as 1)
cfg_max_errors  in  32  error target per point; 0 = disabled
data_finished_blocks  in  64  datapath block counter (cleared by sw reset)
data_bit_errors  in  32  datapath error counter (cleared by sw reset)
data_en  out  1  dataflow enable
data_sw_resetn  out  1  datapath soft reset, active low
data_factor  out  16  current AWGN factor
data_offset  out  8  current AWGN offset
res_valid  out  1  result record valid
res_ready  in  1  result consumer ready
res_point  out  POINT_WIDTH  point index of record
res_factor  out  16  factor used for record
res_blocks  out  64  blocks counted at point
res_errors  out  32  bit errors at point
busy  out  1  high in any state except IDLE/DONE
done  out  1  high in DONE

Behaviour:
- Reset: state IDLE; data_en=0, data_sw_resetn=1, data_factor=0, data_offset=0, res_valid=0, all res_* = 0, busy=0, done=0.
- All cfg_* sampled into internal registers on accepted cfg_start; later cfg changes do not affect a running sweep.
- States: IDLE, RESET, RUN, DRAIN, REPORT, DONE.
- IDLE/DONE + cfg_start: point=0, factor=cfg_factor_init; if cfg_num_points==0 -> DONE, else -> RESET. data_factor/data_offset update the same edge.
- RESET: data_sw_resetn=0 for exactly RESET_CYCLES cycles, data_en=0; then -> RUN.
- RUN: data_en=1. Stop when data_finished_blocks >= max_blocks OR (max_errors!=0 AND data_bit_errors >= max_errors), compared on registered inputs; -> DRAIN the cycle after condition is seen.
- DRAIN: data_en=0 for DRAIN_CYCLES cycles; on last cycle capture counters into res_blocks/res_errors, res_point=point, res_factor=factor; -> REPORT.
- REPORT: res_valid=1; res_* stable until res_valid&&res_ready. On handshake: res_valid=0 next cycle; if point==num_points-1 -> DONE, else point+1, factor=factor+step saturating at 16'hFFFF, -> RESET. No new record while valid is unacknowledged (datapath stays disabled).
- DONE: done=1, data_en=0; holds until cfg_start (restart) or reset.
- cfg_abort in any non-IDLE state: next cycle -> IDLE, data_en=0, data_sw_resetn=1, res_valid=0 (pending record dropped). Abort wins over simultaneous start and handshake.
- cfg_start while busy: ignored.
- data_resetn low mid-sweep: immediate return to reset values next edge.

Test Plan:
- Start with init=0x1000, step=0x0100, num=3, max_blocks=10, max_errors=0, res_ready=1, counters incrementing 1/cycle -> three records, points 0..2, factors 0x1000/0x1100/0x1200, res_blocks>=10, then done=1.
- max_blocks=1000, max_errors=5, errors reach 5 at block 40 -> RUN exits on errors, record res_errors>=5, res_blocks<1000.
- res_ready held low 50 cycles in REPORT -> res_valid and res_* stable, data_en=0, no reset pulse until ready.
- init=0xFF80, step=0x0100, num=2 -> second factor 0xFFFF (saturated).
- cfg_abort during RUN of point 1 -> data_en=0 and IDLE next cycle, no further records; cfg_start then restarts at point 0.
- cfg_num_points=0 -> DONE one cycle after start, no sw reset pulse, no record; data_sw_resetn low exactly RESET_CYCLES=4 cycles per point in other tests.

Source files
------------

// File: rtl/ldpc_ber_sweep_ctrl.sv
// ldpc_ber_sweep_ctrl: data-domain sequencer stepping the LDPC BER datapath through an SNR sweep
module ldpc_ber_sweep_ctrl #(
    parameter int RESET_CYCLES = 4,
    parameter int DRAIN_CYCLES = 64,
    parameter int POINT_WIDTH  = 8
) (
    input  logic                   data_clk,
    input  logic                   data_resetn,
    input  logic                   cfg_start,
    input  logic                   cfg_abort,
    input  logic [15:0]            cfg_factor_init,
    input  logic [15:0]            cfg_factor_step,
    input  logic [7:0]             cfg_offset,
    input  logic [POINT_WIDTH-1:0] cfg_num_points,
    input  logic [63:0]            cfg_max_blocks,
    input  logic [31:0]            cfg_max_errors,
    input  logic [63:0]            data_finished_blocks,
    input  logic [31:0]            data_bit_errors,
    output logic                   data_en,
    output logic                   data_sw_resetn,
    output logic [15:0]            data_factor,
    output logic [7:0]             data_offset,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [POINT_WIDTH-1:0] res_point,
    output logic [15:0]            res_factor,
    output logic [63:0]            res_blocks,
    output logic [31:0]            res_errors,
    output logic                   busy,
    output logic                   done
);
    localparam int CNT_MAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int CW = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET, S_RUN, S_DRAIN, S_REPORT, S_DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    logic [POINT_WIDTH-1:0] point_q;
    logic [POINT_WIDTH-1:0] num_q;
    logic [15:0]            step_q;
    logic [63:0]            max_blocks_q;
    logic [31:0]            max_errors_q;
    logic [63:0]            blocks_q;
    logic [31:0]            errors_q;
    logic [16:0]            factor_sum;
    logic [15:0]            factor_next;
    logic                   stop_hit;
    logic                   last_point;

    // stop decision, saturating factor step and last-point detect
    always_comb begin
        stop_hit    = (blocks_q >= max_blocks_q) || (max_errors_q != 32'd0 && errors_q >= max_errors_q);
        factor_sum  = {1'b0, data_factor} + {1'b0, step_q};
        factor_next = factor_sum[16] ? 16'hFFFF : factor_sum[15:0];
        last_point  = point_q == (num_q - POINT_WIDTH'(1));
    end

    // register datapath counters; forced to zero while the datapath is held in soft reset
    // so a stale count from the previous point can never end the next RUN early
    always_ff @(posedge data_clk) begin
        if (!data_resetn) begin
            blocks_q <= '0;
            errors_q <= '0;
        end else begin
            blocks_q <= data_sw_resetn ? data_finished_blocks : 64'd0;
            errors_q <= data_sw_resetn ? data_bit_errors : 32'd0;
        end
    end

    // sweep sequencer with registered datapath controls and result record
    always_ff @(posedge data_clk) begin
        if (!data_resetn) begin
            state          <= S_IDLE;
            cnt            <= '0;
            point_q        <= '0;
            num_q          <= '0;
            step_q         <= '0;
            max_blocks_q   <= '0;
            max_errors_q   <= '0;
            data_en        <= 1'b0;
            data_sw_resetn <= 1'b1;
            data_factor    <= '0;
            data_offset    <= '0;
            res_valid      <= 1'b0;
            res_point      <= '0;
            res_factor     <= '0;
            res_blocks     <= '0;
            res_errors     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else if (cfg_abort && state != S_IDLE) begin
            state          <= S_IDLE;
            data_en        <= 1'b0;
            data_sw_resetn <= 1'b1;
            res_valid      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        point_q      <= '0;
                        num_q        <= cfg_num_points;
                        step_q       <= cfg_factor_step;
                        max_blocks_q <= (cfg_max_blocks == 64'd0) ? 64'd1 : cfg_max_blocks;
                        max_errors_q <= cfg_max_errors;
                        data_factor  <= cfg_factor_init;
                        data_offset  <= cfg_offset;
                        if (cfg_num_points == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state          <= S_RESET;
                            cnt            <= CW'(RESET_CYCLES - 1);
                            data_sw_resetn <= 1'b0;
                            busy           <= 1'b1;
                            done           <= 1'b0;
                        end
                    end
                end
                S_RESET: begin
                    if (cnt == '0) begin
                        state          <= S_RUN;
                        data_sw_resetn <= 1'b1;
                        data_en        <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RUN: begin
                    if (stop_hit) begin
                        state   <= S_DRAIN;
                        data_en <= 1'b0;
                        cnt     <= CW'(DRAIN_CYCLES - 1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == '0) begin
                        state      <= S_REPORT;
                        res_valid  <= 1'b1;
                        res_point  <= point_q;
                        res_factor <= data_factor;
                        res_blocks <= blocks_q;
                        res_errors <= errors_q;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (last_point) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state          <= S_RESET;
                            point_q        <= point_q + POINT_WIDTH'(1);
                            data_factor    <= factor_next;
                            cnt            <= CW'(RESET_CYCLES - 1);
                            data_sw_resetn <= 1'b0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ldpc_ber_sweep_ctrl.sv
// tb_ldpc_ber_sweep_ctrl: randomized sweep bench with a behavioural datapath and record model
module tb_ldpc_ber_sweep_ctrl;
    logic        data_clk = 1'b0;
    logic        data_resetn;
    logic        cfg_start, cfg_abort;
    logic [15:0] cfg_factor_init, cfg_factor_step;
    logic [7:0]  cfg_offset, cfg_num_points;
    logic [63:0] cfg_max_blocks;
    logic [31:0] cfg_max_errors;
    logic [63:0] dp_blocks = '0;
    logic [31:0] dp_errors = '0;
    logic        data_en, data_sw_resetn, res_valid, res_ready, busy, done;
    logic [15:0] data_factor, res_factor;
    logic [7:0]  data_offset, res_point;
    logic [63:0] res_blocks;
    logic [31:0] res_errors;
    int          n_checks = 0;
    int          n_fail = 0;
    int          err_p = 0;
    int          sw_low = 0;

    always #5 data_clk = ~data_clk;

    ldpc_ber_sweep_ctrl dut (
        .data_clk(data_clk), .data_resetn(data_resetn),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_factor_init(cfg_factor_init), .cfg_factor_step(cfg_factor_step),
        .cfg_offset(cfg_offset), .cfg_num_points(cfg_num_points),
        .cfg_max_blocks(cfg_max_blocks), .cfg_max_errors(cfg_max_errors),
        .data_finished_blocks(dp_blocks), .data_bit_errors(dp_errors),
        .data_en(data_en), .data_sw_resetn(data_sw_resetn),
        .data_factor(data_factor), .data_offset(data_offset),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_point(res_point), .res_factor(res_factor),
        .res_blocks(res_blocks), .res_errors(res_errors),
        .busy(busy), .done(done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // datapath stand-in: one block per enabled cycle, one bit error every err_p blocks
    always @(posedge data_clk) begin
        if (!data_sw_resetn) begin
            dp_blocks <= '0;
            dp_errors <= '0;
        end else if (data_en) begin
            dp_blocks <= dp_blocks + 64'd1;
            if (err_p != 0 && (dp_blocks + 64'd1) % err_p == 0) dp_errors <= dp_errors + 32'd1;
        end
    end

    // every soft reset pulse must last exactly four cycles
    always @(negedge data_clk) begin
        if (data_resetn) begin
            if (!data_sw_resetn) sw_low++;
            else if (sw_low != 0) begin
                check_eq("swrst_len", 64'(sw_low), 64'd4);
                sw_low = 0;
            end
        end
    end

    function automatic logic [15:0] exp_factor(input logic [15:0] init, input logic [15:0] step, input int i);
        longint t;
        t = longint'(init) + longint'(i) * longint'(step);
        return (t > 65535) ? 16'hFFFF : 16'(t);
    endfunction

    // first block count at which the stop rule holds, plus the two register stages
    // (input sample, then state change) during which the datapath keeps counting
    function automatic longint exp_blocks(input longint maxb, input longint maxe, input int p);
        longint mb, b;
        mb = (maxb == 0) ? 1 : maxb;
        b = 0;
        while (!(b >= mb || (maxe != 0 && p != 0 && b / p >= maxe))) b++;
        return b + 2;
    endfunction

    task automatic run_sweep(input logic [15:0] init, input logic [15:0] step, input logic [7:0] num,
                             input logic [63:0] maxb, input logic [31:0] maxe, input int p,
                             input int hold, input int abort_at);
        logic [7:0]  off;
        logic [15:0] ef;
        longint      eb, ee;
        int          n;
        bit          seen;
        off = 8'($urandom);
        err_p = p;
        @(negedge data_clk);
        cfg_factor_init = init; cfg_factor_step = step; cfg_num_points = num;
        cfg_max_blocks = maxb; cfg_max_errors = maxe; cfg_offset = off; cfg_start = 1'b1;
        @(negedge data_clk);
        cfg_start = 1'b0;
        check_eq("start_busy", {busy, done, data_sw_resetn}, 3'b100);
        check_eq("start_factor", {data_factor, data_offset}, {init, off});
        cfg_factor_init = 16'($urandom); cfg_factor_step = 16'($urandom);
        cfg_num_points = 8'($urandom); cfg_max_blocks = 64'($urandom_range(1, 5));
        cfg_max_errors = 32'd1; cfg_offset = ~off; cfg_start = 1'b1;
        @(negedge data_clk);
        cfg_start = 1'b0;
        for (int i = 0; i < int'(num); i++) begin
            ef = exp_factor(init, step, i);
            if (i == abort_at) begin
                n = 0;
                while (!data_en && n < 500) begin @(negedge data_clk); n++; end
                check_eq("abort_run", data_en, 1'b1);
                cfg_abort = 1'b1;
                @(negedge data_clk);
                cfg_abort = 1'b0;
                check_eq("abort_state", {data_en, data_sw_resetn, res_valid, busy, done}, 5'b01000);
                seen = 0;
                repeat (150) begin
                    @(negedge data_clk);
                    if (res_valid || data_en || !data_sw_resetn) seen = 1;
                end
                check_eq("abort_quiet", seen, 1'b0);
                return;
            end
            n = 0;
            while (!res_valid && n < 2000) begin @(negedge data_clk); n++; end
            check_eq("rec_timeout", res_valid, 1'b1);
            if (!res_valid) return;
            eb = exp_blocks(longint'(maxb), longint'(maxe), p);
            ee = (p == 0) ? 0 : eb / p;
            check_eq("rec_point", res_point, 8'(i));
            check_eq("rec_factor", res_factor, ef);
            check_eq("rec_blocks", res_blocks, 64'(eb));
            check_eq("rec_errors", res_errors, 64'(ee));
            check_eq("rec_ctrl", {data_en, data_sw_resetn, data_factor, data_offset}, {2'b01, ef, off});
            for (int h = 0; h < hold; h++) begin
                @(negedge data_clk);
                check_eq("hold", {res_valid, data_en, data_sw_resetn, res_point, res_factor, res_blocks[15:0]},
                         {3'b101, 8'(i), ef, 16'(eb)});
            end
            res_ready = 1'b1;
            @(negedge data_clk);
            res_ready = 1'b0;
            check_eq("valid_clr", res_valid, 1'b0);
            if (i == int'(num) - 1) check_eq("sweep_done", {done, busy, data_en}, 3'b100);
            else check_eq("next_point", {data_sw_resetn, busy, data_factor},
                          {2'b01, exp_factor(init, step, i + 1)});
        end
    endtask

    initial begin
        int n;
        bit seen;
        data_resetn = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; res_ready = 1'b0;
        cfg_factor_init = '0; cfg_factor_step = '0; cfg_offset = '0; cfg_num_points = '0;
        cfg_max_blocks = '0; cfg_max_errors = '0;
        repeat (3) @(negedge data_clk);
        check_eq("rst_ctrl", {data_en, data_sw_resetn, busy, done, res_valid}, 5'b01000);
        check_eq("rst_factor", {data_factor, data_offset, res_point, res_factor}, 64'd0);
        check_eq("rst_blocks", res_blocks, 64'd0);
        check_eq("rst_errors", res_errors, 64'd0);
        data_resetn = 1'b1;

        run_sweep(16'h1000, 16'h0100, 8'd3, 64'd10, 32'd0, 0, 0, -1);
        run_sweep(16'h2000, 16'h0010, 8'd1, 64'd1000, 32'd5, 8, 0, -1);
        run_sweep(16'h0800, 16'h0040, 8'd2, 64'd20, 32'd0, 3, 50, -1);
        run_sweep(16'hFF80, 16'h0100, 8'd2, 64'd10, 32'd0, 0, 0, -1);
        run_sweep(16'h3000, 16'h0200, 8'd3, 64'd15, 32'd0, 0, 0, 1);
        run_sweep(16'h4000, 16'h0001, 8'd2, 64'd0, 32'd2, 4, 0, -1);

        @(negedge data_clk);
        cfg_num_points = 8'd0; cfg_factor_init = 16'h1234; cfg_start = 1'b1;
        @(negedge data_clk);
        cfg_start = 1'b0;
        check_eq("zero_pts", {done, busy, data_sw_resetn, res_valid, data_en}, 5'b10100);
        check_eq("zero_factor", data_factor, 16'h1234);
        seen = 0;
        repeat (20) begin
            @(negedge data_clk);
            if (res_valid || !data_sw_resetn || !done) seen = 1;
        end
        check_eq("zero_quiet", seen, 1'b0);

        @(negedge data_clk);
        cfg_num_points = 8'd2; cfg_max_blocks = 64'd30; cfg_start = 1'b1;
        @(negedge data_clk);
        cfg_start = 1'b0;
        n = 0;
        while (!data_en && n < 500) begin @(negedge data_clk); n++; end
        check_eq("mid_run", data_en, 1'b1);
        data_resetn = 1'b0;
        @(negedge data_clk);
        check_eq("mid_rst_ctrl", {data_en, data_sw_resetn, busy, done, res_valid}, 5'b01000);
        check_eq("mid_rst_factor", {data_factor, data_offset}, 64'd0);
        data_resetn = 1'b1;

        for (int k = 0; k < 4; k++)
            run_sweep(16'($urandom), 16'($urandom), 8'($urandom_range(1, 3)), 64'($urandom_range(0, 40)),
                      32'($urandom_range(0, 6)), int'($urandom_range(0, 9)), int'($urandom_range(0, 3)), -1);

        repeat (5) @(negedge data_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
